apd_dac_spi_drive: RTL and testbench

Serial DAC driver that sits directly downstream of the temperature-compensation stage. It consumes the `set_en` strobe and 16-bit `da_count` word that set the APD high-voltage DAC and shifts each word out as a 16-bit SPI frame. Requests arriving mid-frame are coalesced, so only the latest word is kept. An optional slew limiter steps the 10-bit DAC code toward the target across several frames.

---
 rtl/apd_dac_spi_drive_if.sv | 34 +++
 rtl/apd_dac_spi_drive.sv | 176 +++++++++++++++++
 tb/tb_apd_dac_spi_drive.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apd_dac_spi_drive_if.sv
// Request / SPI pin bundle between the temperature-compensation stage, the DAC
// driver and the APD high-voltage DAC.
interface apd_dac_spi_drive_if;
    logic        set_en;
    logic [15:0] da_count;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_din;
    logic        busy;
    logic        done;
    logic [15:0] cur_code;

    modport master (
        output set_en,
        output da_count,
        input  dac_cs_n,
        input  dac_sclk,
        input  dac_din,
        input  busy,
        input  done,
        input  cur_code
    );

    modport slave (
        input  set_en,
        input  da_count,
        output dac_cs_n,
        output dac_sclk,
        output dac_din,
        output busy,
        output done,
        output cur_code
    );
endinterface

// File: rtl/apd_dac_spi_drive.sv
// APD high-voltage DAC driver: coalesces requests and shifts 16-bit SPI frames MSB first.
// Optional slew limiting of the code field [11:2] is compiled in with `define DAC_RAMP_EN.
module apd_dac_spi_drive #(
    parameter int CLK_DIV  = 4,
    parameter int CS_GUARD = 8,
    parameter int MAX_STEP = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    apd_dac_spi_drive_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GRD_W = $clog2(CS_GUARD + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(CS_GUARD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_bit_cnt;
    logic [GRD_W-1:0] r_guard_cnt;
    logic [15:0]      r_shift;
    logic [15:0]      r_frame_word;
    logic             r_pend_valid;
    logic [15:0]      r_pend_word;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_din;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_cur_code;

    logic [15:0]      w_next_req;
    logic [15:0]      w_next_word;
    logic             w_ramp_chain;
    logic             w_guard_end;
    logic             w_load;

    // Out-of-range settings elaborate this marker block, making them easy to spot.
    if (CLK_DIV < 2 || CS_GUARD < 1 || MAX_STEP < 1) begin : g_illegal_cfg
        localparam int ILLEGAL_CFG = 1;
    end

`ifdef DAC_RAMP_EN
    function automatic logic [9:0] f_ramp_step(input logic [9:0] cur, input logic [9:0] tgt);
        logic [9:0] lim;
        logic [9:0] diff;
        logic [9:0] res;
        lim = (MAX_STEP > 1023) ? 10'd1023 : 10'(MAX_STEP);
        if (tgt >= cur) begin
            diff = tgt - cur;
            res  = cur + ((diff > lim) ? lim : diff);
        end else begin
            diff = cur - tgt;
            res  = cur - ((diff > lim) ? lim : diff);
        end
        return res;
    endfunction
`endif

    // Next frame word; a same-cycle request overrides the pending word.
    always_comb begin
        w_next_req   = bus.set_en ? bus.da_count : r_pend_word;
`ifdef DAC_RAMP_EN
        w_next_word  = {w_next_req[15:12],
                        f_ramp_step(r_cur_code[11:2], w_next_req[11:2]),
                        w_next_req[1:0]};
        w_ramp_chain = (w_next_req[11:2] != r_cur_code[11:2]);
`else
        w_next_word  = w_next_req;
        w_ramp_chain = 1'b0;
`endif
        w_guard_end  = (r_state == ST_GUARD) && (r_guard_cnt == GRD_LAST);
        w_load       = ((r_state == ST_IDLE) && (bus.set_en || r_pend_valid)) ||
                       (w_guard_end && w_ramp_chain);
    end

    // Frame sequencer, pending-request capture and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= {DIV_W{1'b0}};
            r_bit_cnt    <= 4'd0;
            r_guard_cnt  <= {GRD_W{1'b0}};
            r_shift      <= 16'h0000;
            r_frame_word <= 16'h0000;
            r_pend_valid <= 1'b0;
            r_pend_word  <= 16'h0000;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_din        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cur_code   <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            if (bus.set_en) begin
                r_pend_word <= bus.da_count;
            end
            if (w_load) begin
                r_pend_valid <= 1'b0;
            end else if (bus.set_en) begin
                r_pend_valid <= 1'b1;
            end

            if (w_load) begin
                r_state      <= ST_SHIFT;
                r_shift      <= w_next_word;
                r_frame_word <= w_next_word;
                r_din        <= w_next_word[15];
                r_cs_n       <= 1'b0;
                r_sclk       <= 1'b0;
                r_busy       <= 1'b1;
                r_div_cnt    <= {DIV_W{1'b0}};
                r_bit_cnt    <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (r_div_cnt == DIV_LAST) begin
                            r_div_cnt <= {DIV_W{1'b0}};
                            if (!r_sclk) begin
                                r_sclk <= 1'b1;
                            end else if (r_bit_cnt == 4'd15) begin
                                r_sclk      <= 1'b0;
                                r_cs_n      <= 1'b1;
                                r_din       <= 1'b0;
                                r_done      <= 1'b1;
                                r_cur_code  <= r_frame_word;
                                r_guard_cnt <= {GRD_W{1'b0}};
                                r_state     <= ST_GUARD;
                            end else begin
                                // Data moves on the falling edge so it is settled a full half-period before sampling.
                                r_sclk    <= 1'b0;
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_shift   <= {r_shift[14:0], 1'b0};
                                r_din     <= r_shift[14];
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (w_guard_end) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_guard_cnt <= r_guard_cnt + GRD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cs_n  <= 1'b1;
                        r_sclk  <= 1'b0;
                        r_din   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dac_cs_n = r_cs_n;
    assign bus.dac_sclk = r_sclk;
    assign bus.dac_din  = r_din;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.cur_code = r_cur_code;
endmodule

// File: tb/tb_apd_dac_spi_drive.sv
// Self-checking bench for apd_dac_spi_drive: table vectors, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_apd_dac_spi_drive;
    localparam int CLK_DIV   = 4;
    localparam int CS_GUARD  = 8;
    localparam int MAX_STEP  = 16;
    localparam int FRAME_LEN = 32 * CLK_DIV + CS_GUARD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    apd_dac_spi_drive_if bus();

    apd_dac_spi_drive #(.CLK_DIV(CLK_DIV), .CS_GUARD(CS_GUARD), .MAX_STEP(MAX_STEP)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          start;
        int          first_rise;
        int          cs_low;
    } frame_t;

    frame_t rx_q[$];
    frame_t mon;
    logic   prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    int     done_cnt = 0, busy_falls = 0, last_busy_fall = 0;

    // SPI pin monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0;
        end else begin
            if (!bus.dac_cs_n && prev_cs) begin
                mon.bits = 16'h0000; mon.nbits = 0; mon.start = cyc; mon.first_rise = -1; mon.cs_low = 0;
            end
            if (!bus.dac_cs_n) mon.cs_low++;
            if (bus.dac_sclk && !prev_sclk && !bus.dac_cs_n) begin
                mon.bits = {mon.bits[14:0], bus.dac_din};
                if (mon.nbits == 0) mon.first_rise = cyc;
                mon.nbits++;
            end
            if (bus.dac_cs_n && !prev_cs) rx_q.push_back(mon);
            if (bus.done) done_cnt++;
            if (!bus.busy && prev_busy) begin
                last_busy_fall = cyc; busy_falls++;
            end
            prev_cs = bus.dac_cs_n; prev_sclk = bus.dac_sclk; prev_busy = bus.busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic req(input logic [15:0] w, output int t);
        tick();
        bus.set_en = 1'b1; bus.da_count = w;
        t = cyc + 1;
        tick();
        bus.set_en = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick(); k++;
        end
        chk("frames_seen", rx_q.size(), n);
    endtask

    task automatic do_reset();
        bus.set_en = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_bits;
        int          exp_edges;
        int          exp_cs_low;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    int   m_busy_until;
    logic m_pend;
    logic [15:0] m_pend_word;

    // Frame-level reference: a request on an idle edge starts a frame; otherwise it replaces the pending word.
    task automatic model_step(input int n, input logic se, input logic [15:0] da);
        exp_t e;
        if (n > m_busy_until) begin
            if (se || m_pend) begin
                e.word = se ? da : m_pend_word;
                e.start = n;
                exp_q.push_back(e);
                m_busy_until = n + FRAME_LEN;
                m_pend = 1'b0;
            end
        end else if (se) begin
            m_pend = 1'b1; m_pend_word = da;
        end
    endtask

    initial begin
        vec_t        vecs[6];
        frame_t      f;
        int          t, t2, d0, f0, k, hold;
        logic        se;
        logic [15:0] da;

        vecs[0] = '{16'h8A28, 16'h8A28, 16, 128, 136};
        vecs[1] = '{16'h0000, 16'h0000, 16, 128, 136};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16, 128, 136};
        vecs[3] = '{16'h0001, 16'h0001, 16, 128, 136};
        vecs[4] = '{16'h8000, 16'h8000, 16, 128, 136};
        vecs[5] = '{16'h5A5A, 16'h5A5A, 16, 128, 136};

        bus.set_en = 1'b0; bus.da_count = 16'h0000;
        repeat (3) tick();
        chk("rst_cs_n", bus.dac_cs_n, 1); chk("rst_sclk", bus.dac_sclk, 0);
        chk("rst_din", bus.dac_din, 0);   chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);     chk("rst_cur_code", bus.cur_code, 16'h0000);
        rst = 1'b0;
        tick();

        // Reset in the middle of a frame after seven bits
        req(16'h1234, t);
        k = 0;
        while (!(!bus.dac_cs_n && mon.nbits >= 7) && k < 200) begin
            tick(); k++;
        end
        chk("midrst_reached_bit7", mon.nbits, 7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cs_n", bus.dac_cs_n, 1); chk("midrst_sclk", bus.dac_sclk, 0);
        chk("midrst_busy", bus.busy, 0);     chk("midrst_din", bus.dac_din, 0);
        chk("midrst_cur_code", bus.cur_code, 16'h0000);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("midrst_no_frame", rx_q.size(), 0);
        req(16'h8010, t);
        wait_frames(1, FRAME_LEN + 20);
        if (rx_q.size() > 0) begin
            f = rx_q.pop_front();
            chk("postrst_bits", f.bits, 16'h8010); chk("postrst_nbits", f.nbits, 16);
        end
        repeat (CS_GUARD + 4) tick();

`ifndef DAC_RAMP_EN
        for (int i = 0; i < 6; i++) begin
            rx_q.delete();
            d0 = done_cnt;
            req(vecs[i].word, t);
            wait_frames(1, FRAME_LEN + 20);
            repeat (CS_GUARD + 3) tick();
            if (rx_q.size() > 0) begin
                f = rx_q.pop_front();
                chk("vec_bits", f.bits, vecs[i].exp_bits);
                chk("vec_sclk_edges", f.nbits, vecs[i].exp_edges);
                chk("vec_cs_start", f.start - t, 0);
                chk("vec_first_rise", f.first_rise - t, CLK_DIV);
                chk("vec_cs_low", f.cs_low, vecs[i].exp_cs_low);
            end
            chk("vec_busy_len", last_busy_fall - t, vecs[i].exp_busy);
            chk("vec_cur_code", bus.cur_code, vecs[i].word);
            chk("vec_done_cnt", done_cnt - d0, 1);
        end

        // Coalescing: the middle request is overwritten while the first frame shifts
        rx_q.delete();
        req(16'h8100, t);
        repeat (20) tick();
        req(16'h8200, t2);
        repeat (10) tick();
        req(16'h8300, t2);
        wait_frames(2, 2 * FRAME_LEN + 40);
        repeat (FRAME_LEN + 10) tick();
        chk("coal_frame_total", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("coal_first", rx_q[0].bits, 16'h8100);
            chk("coal_second", rx_q[1].bits, 16'h8300);
            chk("coal_second_start", rx_q[1].start - t, FRAME_LEN + 1);
        end

        // Request coincident with the done edge
        rx_q.delete();
        req(16'h1111, t);
        while (cyc + 1 < t + 32 * CLK_DIV) tick();
        bus.set_en = 1'b1; bus.da_count = 16'h8040;
        tick();
        bus.set_en = 1'b0;
        chk("simul_done_edge", bus.done, 1);
        wait_frames(2, 2 * FRAME_LEN + 20);
        if (rx_q.size() >= 2) begin
            chk("simul_bits", rx_q[1].bits, 16'h8040);
            chk("simul_start", rx_q[1].start - t, FRAME_LEN + 1);
        end
        repeat (CS_GUARD + 4) tick();

        // Randomized traffic, including long set_en holds
        rx_q.delete();
        exp_q.delete();
        m_busy_until = cyc;
        m_pend = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000 + 2 * FRAME_LEN + 10; i++) begin
            tick();
            if (i >= 3000) begin
                se = 1'b0;
            end else if (hold > 0) begin
                se = 1'b1; hold--;
            end else begin
                se = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 199) == 0) hold = $urandom_range(5, 300);
            end
            da = 16'($urandom);
            bus.set_en = se; bus.da_count = da;
            model_step(cyc + 1, se, da);
        end
        bus.set_en = 1'b0;
        chk("rand_frame_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            chk("rand_word", rx_q[i].bits, exp_q[i].word);
            chk("rand_start", rx_q[i].start, exp_q[i].start);
        end
`else
        begin
            logic [15:0] exp_codes[5];
            logic [9:0]  code10;
            int          code;
            int          step;

            // Ramp from zero to code field 100
            do_reset();
            rx_q.delete();
            d0 = done_cnt; f0 = busy_falls;
            req(16'h8190, t);
            wait_frames(7, 7 * (FRAME_LEN + 1) + 50);
            repeat (CS_GUARD + 5) tick();
            code = 0;
            for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
                step = 100 - code;
                if (step > MAX_STEP) step = MAX_STEP;
                code = code + step;
                code10 = 10'(code);
                chk("ramp_word", rx_q[i].bits, {4'h8, code10, 2'b00});
            end
            chk("ramp_done_cnt", done_cnt - d0, 7);
            chk("ramp_busy_falls", busy_falls - f0, 1);
            chk("ramp_cur_code", bus.cur_code, 16'h8190);

            // Retarget to code field 20 while the frame carrying 48 shifts
            exp_codes[0] = 16'd16; exp_codes[1] = 16'd32; exp_codes[2] = 16'd48;
            exp_codes[3] = 16'd32; exp_codes[4] = 16'd20;
            do_reset();
            rx_q.delete();
            req(16'h8190, t);
            k = 0;
            while (!(rx_q.size() == 2 && !bus.dac_cs_n) && k < 1000) begin
                tick(); k++;
            end
            req(16'h8050, t2);
            wait_frames(5, 4 * (FRAME_LEN + 1) + 50);
            repeat (FRAME_LEN + 10) tick();
            chk("retarget_frames", rx_q.size(), 5);
            for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
                code10 = exp_codes[i][9:0];
                chk("retarget_word", rx_q[i].bits, {4'h8, code10, 2'b00});
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
